// File: rtl/vga_state_fetcher_if.sv
// Frame trigger, DataMemory port B and snapshot readout signals of vga_state_fetcher.
interface vga_state_fetcher_if #(
    parameter int NUM_WORDS = 8,
    parameter int SEL_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
);
    logic             frame_start;
    logic             fetch_en;
    logic [31:0]      VGAAddr;
    logic [31:0]      DataVideo;
    logic [SEL_W-1:0] word_sel;
    logic [31:0]      word_out;
    logic             snapshot_valid;
    logic             snapshot_done;
    logic             busy;
    logic             overrun;
    logic             clear_overrun;

    // Fetcher side: drives the read address and the snapshot status/readout.
    modport master (
        input  frame_start, fetch_en, DataVideo, word_sel, clear_overrun,
        output VGAAddr, word_out, snapshot_valid, snapshot_done, busy, overrun
    );

    // System side: timing generator, memory port B and renderer.
    modport slave (
        output frame_start, fetch_en, DataVideo, word_sel, clear_overrun,
        input  VGAAddr, word_out, snapshot_valid, snapshot_done, busy, overrun
    );
endinterface

// File: rtl/vga_state_fetcher.sv
// Once-per-frame burst reader of game-state words from DataMemory port B.
// Words land in a shadow file and are copied to the snapshot in a single
// commit cycle, so the renderer never sees a mix of two frames.
module vga_state_fetcher #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          NUM_WORDS    = 8,
    parameter logic [31:0] ADDR_STRIDE  = 32'd4,
    parameter int          READ_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset,
    vga_state_fetcher_if.master bus
);
    localparam int SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] NW   = CNT_W'(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  iss_cnt, iss_cnt_n;
    logic [CNT_W-1:0]  cap_cnt;
    logic [31:0]       addr_q, addr_n;
    logic              issue;
    // vld_p[0] tags the address on the bus this cycle; vld_p[READ_LATENCY]
    // marks the cycle in which its read data is valid on DataVideo.
    logic [READ_LATENCY:0] vld_p;
    logic [31:0]       shadow   [NUM_WORDS];
    logic [31:0]       snapshot [NUM_WORDS];
    logic              start, all_captured, capture, commit, sel_ok;
    logic              done_q, valid_q, overrun_q;
    logic [31:0]       word_q;

    assign start        = bus.frame_start && bus.fetch_en && (state == IDLE);
    assign all_captured = (cap_cnt == NW);
    assign capture      = vld_p[READ_LATENCY] && !all_captured;
    assign commit       = (state == DRAIN) && all_captured;

    // Out-of-range selects only exist when NUM_WORDS is not a power of two.
    generate
        if (NUM_WORDS == (1 << SEL_W)) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_part
            assign sel_ok = (bus.word_sel < SEL_W'(NUM_WORDS));
        end
    endgenerate

    // Next-state, next address and issue decision.
    always_comb begin
        state_n   = state;
        iss_cnt_n = iss_cnt;
        addr_n    = addr_q;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                addr_n = BASE_ADDR;
                if (start) begin
                    issue     = 1'b1;
                    iss_cnt_n = CNT_W'(1);
                    state_n   = (NUM_WORDS == 1) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                issue     = 1'b1;
                addr_n    = BASE_ADDR + ADDR_STRIDE * 32'(iss_cnt);
                iss_cnt_n = iss_cnt + 1'b1;
                if (iss_cnt == LAST) state_n = DRAIN;
            end
            DRAIN: begin
                if (all_captured) state_n = COMMIT;
            end
            COMMIT: begin
                addr_n  = BASE_ADDR;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, read address and issue-tag pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            iss_cnt <= '0;
            addr_q  <= BASE_ADDR;
            vld_p   <= '0;
        end else begin
            state   <= state_n;
            iss_cnt <= iss_cnt_n;
            addr_q  <= addr_n;
            vld_p   <= {vld_p[READ_LATENCY-1:0], issue};
        end
    end

    // In-order capture of returning read data into the shadow file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_cnt <= '0;
            for (int i = 0; i < NUM_WORDS; i++) shadow[i] <= '0;
        end else if (start) begin
            cap_cnt <= '0;
        end else if (capture) begin
            shadow[cap_cnt[SEL_W-1:0]] <= bus.DataVideo;
            cap_cnt <= cap_cnt + 1'b1;
        end
    end

    // Atomic commit of the whole shadow file into the snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) snapshot[i] <= '0;
        end else begin
            done_q <= commit;
            if (commit) begin
                valid_q  <= 1'b1;
                snapshot <= shadow;
            end
        end
    end

    // Sticky overrun (a new event beats clear) and registered word readout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
            word_q    <= '0;
        end else begin
            if (bus.frame_start && (state != IDLE)) overrun_q <= 1'b1;
            else if (bus.clear_overrun)             overrun_q <= 1'b0;
            word_q <= sel_ok ? snapshot[bus.word_sel] : 32'h0;
        end
    end

    assign bus.VGAAddr        = addr_q;
    assign bus.busy           = (state != IDLE);
    assign bus.snapshot_done  = done_q;
    assign bus.snapshot_valid = valid_q;
    assign bus.overrun        = overrun_q;
    assign bus.word_out       = word_q;
endmodule

// File: tb/tb_vga_state_fetcher.sv
// Bench for vga_state_fetcher: two instances (8 words/latency 1 and a
// 5-word/latency 3 instance whose addresses wrap past 2^32) share stimulus
// and are compared every cycle against a frame-timeline reference model.
module tb_vga_state_fetcher;
    localparam logic [31:0] A_BASE = 32'h0000_0100, B_BASE = 32'hFFFF_FFF0;
    localparam logic [31:0] A_STR  = 32'd4,         B_STR  = 32'd8;
    localparam int          A_N = 8, A_RL = 1, B_N = 5, B_RL = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fs = 1'b0, en = 1'b1, clr = 1'b0;
    logic [2:0]  sel = '0;
    logic [15:0] key = 16'hA5A5;
    bit          chk_on = 1'b0;
    int          n_vec = 0, n_err = 0, cyc = 0;

    always #20 clk = ~clk;

    vga_state_fetcher_if #(.NUM_WORDS(A_N)) bus_a ();
    vga_state_fetcher_if #(.NUM_WORDS(B_N)) bus_b ();

    assign bus_a.frame_start = fs;  assign bus_b.frame_start = fs;
    assign bus_a.fetch_en = en;     assign bus_b.fetch_en = en;
    assign bus_a.clear_overrun = clr; assign bus_b.clear_overrun = clr;
    assign bus_a.word_sel = sel;    assign bus_b.word_sel = sel;

    vga_state_fetcher #(.BASE_ADDR(A_BASE), .NUM_WORDS(A_N), .ADDR_STRIDE(A_STR),
                        .READ_LATENCY(A_RL)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
    vga_state_fetcher #(.BASE_ADDR(B_BASE), .NUM_WORDS(B_N), .ADDR_STRIDE(B_STR),
                        .READ_LATENCY(B_RL)) u_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Memory port B models: data = {key, addr[15:0]}, READ_LATENCY cycles after the address.
    logic [31:0] hist_a [A_RL];
    logic [31:0] hist_b [B_RL];
    always @(posedge clk) begin
        hist_a[0] <= bus_a.VGAAddr;
        for (int j = 1; j < A_RL; j++) hist_a[j] <= hist_a[j-1];
        hist_b[0] <= bus_b.VGAAddr;
        for (int j = 1; j < B_RL; j++) hist_b[j] <= hist_b[j-1];
    end
    assign bus_a.DataVideo = {key, hist_a[A_RL-1][15:0]};
    assign bus_b.DataVideo = {key, hist_b[B_RL-1][15:0]};

    function automatic int nw(int d);            return d == 0 ? A_N : B_N;       endfunction
    function automatic int rl(int d);            return d == 0 ? A_RL : B_RL;     endfunction
    function automatic logic [31:0] base(int d); return d == 0 ? A_BASE : B_BASE; endfunction
    function automatic logic [31:0] strd(int d); return d == 0 ? A_STR : B_STR;   endfunction

    // Reference model: a frame accepted at edge k issues word i in the cycle
    // after edge k+i, commits at edge k+N+RL+1 and frees the block one edge later.
    logic        m_act [2];
    int          m_k   [2];
    logic        m_ovr [2], m_valid [2], m_done [2];
    logic [31:0] m_word [2];
    logic [31:0] m_snap [2][8];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_act[d] <= 1'b0; m_k[d] <= 0; m_ovr[d] <= 1'b0;
                m_valid[d] <= 1'b0; m_done[d] <= 1'b0; m_word[d] <= '0;
                for (int i = 0; i < 8; i++) m_snap[d][i] <= '0;
            end else begin
                m_word[d] <= (int'(sel) < nw(d)) ? m_snap[d][sel] : 32'h0;
                if (fs && m_act[d]) m_ovr[d] <= 1'b1;
                else if (clr)       m_ovr[d] <= 1'b0;
                m_done[d] <= m_act[d] && (cyc == m_k[d] + nw(d) + rl(d) + 1);
                if (m_act[d] && (cyc == m_k[d] + nw(d) + rl(d) + 1)) begin
                    m_valid[d] <= 1'b1;
                    for (int i = 0; i < nw(d); i++)
                        m_snap[d][i] <= {key, 16'(base(d) + strd(d) * 32'(i))};
                end
                if (!m_act[d] && fs && en) begin
                    m_act[d] <= 1'b1;
                    m_k[d]   <= cyc;
                end else if (m_act[d] && (cyc == m_k[d] + nw(d) + rl(d) + 2)) begin
                    m_act[d] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [31:0] exp_addr(int d);
        int off;
        if (!m_act[d]) return base(d);
        off = (cyc - 1) - m_k[d];
        if (off > nw(d) - 1) off = nw(d) - 1;
        return base(d) + strd(d) * 32'(off);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always begin
        @(posedge clk); #5;
        if (chk_on) begin
            check("a_addr",  bus_a.VGAAddr,            exp_addr(0));
            check("a_busy",  32'(bus_a.busy),           32'(m_act[0]));
            check("a_done",  32'(bus_a.snapshot_done),  32'(m_done[0]));
            check("a_valid", 32'(bus_a.snapshot_valid), 32'(m_valid[0]));
            check("a_ovr",   32'(bus_a.overrun),        32'(m_ovr[0]));
            check("a_word",  bus_a.word_out,            m_word[0]);
            check("b_addr",  bus_b.VGAAddr,            exp_addr(1));
            check("b_busy",  32'(bus_b.busy),           32'(m_act[1]));
            check("b_done",  32'(bus_b.snapshot_done),  32'(m_done[1]));
            check("b_valid", 32'(bus_b.snapshot_valid), 32'(m_valid[1]));
            check("b_ovr",   32'(bus_b.overrun),        32'(m_ovr[1]));
            check("b_word",  bus_b.word_out,            m_word[1]);
        end
    end

    task automatic pulse_fs();
        @(negedge clk); fs = 1'b1;
        @(negedge clk); fs = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus_a.busy && !bus_b.busy) break;
        end
        check("idle_timeout", 32'(bus_a.busy | bus_b.busy), 32'h0);
    endtask

    initial begin
        int lat_a, lat_b;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;

        // First frame: snapshot_done latency measured from the accepting edge.
        @(negedge clk); fs = 1'b1;
        lat_a = -1; lat_b = -1;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk); #5;
            fs = 1'b0;
            if (bus_a.snapshot_done && lat_a < 0) lat_a = j;
            if (bus_b.snapshot_done && lat_b < 0) lat_b = j;
        end
        check("a_done_lat", 32'(lat_a), 32'd10);
        check("b_done_lat", 32'(lat_b), 32'd9);
        @(negedge clk); sel = 3'd3;
        @(posedge clk); #5;
        check("a_word3", bus_a.word_out, 32'hA5A5_010C);
        check("b_word3", bus_b.word_out, 32'hA5A5_0008);

        // Second frame with new data, word_sel sweeping: no torn snapshot.
        @(negedge clk); key = 16'hDEAD;
        fs = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk); fs = 1'b0; sel = 3'($urandom);
        end

        // Overrun: second pulse four cycles into a fetch, then clear, then clear vs set.
        pulse_fs();
        repeat (2) @(negedge clk);
        fs = 1'b1; @(negedge clk); fs = 1'b0;
        wait_idle();
        check("a_ovr_set", 32'(bus_a.overrun), 32'd1);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("b_ovr_clr", 32'(bus_b.overrun), 32'd0);
        pulse_fs();
        fs = 1'b1; clr = 1'b1; @(negedge clk); fs = 1'b0; clr = 1'b0;
        check("a_ovr_win", 32'(bus_a.overrun), 32'd1);
        wait_idle();

        // Reset five cycles into a fetch, then a clean fetch with fresh data.
        @(negedge clk); fs = 1'b1;
        @(negedge clk); fs = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1; #1;
        check("rst_a_addr",  bus_a.VGAAddr, A_BASE);
        check("rst_b_addr",  bus_b.VGAAddr, B_BASE);
        check("rst_a_busy",  32'(bus_a.busy), 32'd0);
        check("rst_b_valid", 32'(bus_b.snapshot_valid), 32'd0);
        check("rst_a_word",  bus_a.word_out, 32'h0);
        check("rst_b_ovr",   32'(bus_b.overrun), 32'd0);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        key = 16'h1234;
        pulse_fs();
        wait_idle();

        // fetch_en low: trigger ignored, no overrun; out-of-range select on the 5-word instance.
        en = 1'b0; pulse_fs();
        check("dis_a_busy", 32'(bus_a.busy), 32'd0);
        check("dis_a_addr", bus_a.VGAAddr, A_BASE);
        check("dis_b_ovr",  32'(bus_b.overrun), 32'd0);
        en = 1'b1; sel = 3'd6;
        @(negedge clk); @(negedge clk);
        check("b_sel_oob", bus_b.word_out, 32'h0);

        // Random traffic: triggers, enables, clears and selects.
        for (int j = 0; j < 600; j++) begin
            @(negedge clk);
            if (!m_act[0] && !m_act[1] && $urandom_range(0, 3) == 0) key = 16'($urandom);
            fs  = ($urandom_range(0, 11) == 0);
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 9) == 0);
            sel = 3'($urandom);
        end
        @(negedge clk); fs = 1'b0; clr = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end
endmodule
